// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags: commit writes values,
// rename records the producing ROB entry, roll-back drops every pending tag.
module rename_reg_file #(
    parameter int XLEN      = 32,
    parameter int ROB_IDX_W = 4,
    parameter int NREG      = 32,
    localparam int REG_W    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [REG_W-1:0]     id_rs1,
    input  logic [REG_W-1:0]     id_rs2,
    input  logic                 id_rename_valid,
    input  logic [REG_W-1:0]     id_rd,
    input  logic [ROB_IDX_W-1:0] id_rob_id,
    output logic                 rs1_busy,
    output logic [ROB_IDX_W-1:0] rs1_tag,
    output logic [XLEN-1:0]      rs1_value,
    output logic                 rs2_busy,
    output logic [ROB_IDX_W-1:0] rs2_tag,
    output logic [XLEN-1:0]      rs2_value,
    input  logic                 cm_valid,
    input  logic [REG_W-1:0]     cm_rd,
    input  logic [ROB_IDX_W-1:0] cm_rob_id,
    input  logic [XLEN-1:0]      cm_value,
    input  logic                 roll_back
);

    typedef struct packed {
        logic                 busy;
        logic [ROB_IDX_W-1:0] tag;
        logic [XLEN-1:0]      value;
    } read_port_t;

    logic [XLEN-1:0]      value_q [NREG];
    logic [XLEN-1:0]      value_d [NREG];
    logic                 busy_q  [NREG];
    logic                 busy_d  [NREG];
    logic [ROB_IDX_W-1:0] tag_q   [NREG];
    logic [ROB_IDX_W-1:0] tag_d   [NREG];

    logic commit_en;
    logic rename_en;

    assign commit_en = cm_valid && (cm_rd != '0);
    assign rename_en = id_rename_valid && (id_rd != '0) && !roll_back;

    // A committing result is forwarded only to a reader still waiting on that exact ROB entry.
    function automatic read_port_t read_port(input logic [REG_W-1:0] idx);
        read_port_t r;
        r.busy  = busy_q[idx];
        r.tag   = tag_q[idx];
        r.value = value_q[idx];
        if (idx == '0) begin
            r = '0;
        end else if (commit_en && (cm_rd == idx) && busy_q[idx] && (tag_q[idx] == cm_rob_id)) begin
            r.busy  = 1'b0;
            r.value = cm_value;
        end
        return r;
    endfunction

    read_port_t rs1_rd;
    read_port_t rs2_rd;

    assign rs1_rd    = read_port(id_rs1);
    assign rs2_rd    = read_port(id_rs2);
    assign rs1_busy  = rs1_rd.busy;
    assign rs1_tag   = rs1_rd.tag;
    assign rs1_value = rs1_rd.value;
    assign rs2_busy  = rs2_rd.busy;
    assign rs2_tag   = rs2_rd.tag;
    assign rs2_value = rs2_rd.value;

    always_comb begin
        // NOTE: every next-state array starts as a copy of the current state, so no path leaves it unassigned and no latch is inferred.
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (rdy) begin
            if (roll_back) begin
                for (int i = 0; i < NREG; i++) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (commit_en) begin
                value_d[cm_rd] = cm_value;
                if (tag_q[cm_rd] == cm_rob_id) begin
                    busy_d[cm_rd] = 1'b0;
                end
            end
            // Applied after the commit so a same-register rename wins busy/tag.
            if (rename_en) begin
                busy_d[id_rd] = 1'b1;
                tag_d[id_rd]  = id_rob_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole array is reset because the read ports must show zero values right after reset.
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge state.
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file: directed scenarios, then a random phase
// against a small behavioural model; expectations go through a scoreboard queue.
module tb_rename_reg_file;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [4:0]  id_rs1, id_rs2, id_rd, cm_rd;
    logic        id_rename_valid, cm_valid, roll_back;
    logic [3:0]  id_rob_id, cm_rob_id;
    logic [31:0] cm_value;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_value, rs2_value;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        busy;
        logic [3:0]  tag;
        logic [31:0] value;
    } rd_t;

    rd_t   exp_q  [$];
    bit    care_q [$];
    bit    port_q [$];
    string name_q [$];

    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    always #5 clk = ~clk;

    rename_reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rename_valid(id_rename_valid), .id_rd(id_rd), .id_rob_id(id_rob_id),
        .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_value(rs1_value),
        .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_value(rs2_value),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_rob_id(cm_rob_id), .cm_value(cm_value),
        .roll_back(roll_back)
    );

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got busy/tag/value=%h expected %h", tag, obs, exp);
        end
    endtask

    // port 0 = rs1, 1 = rs2; the tag is compared only when care_tag is set
    task automatic expect_rd(input string name, input bit port, input logic busy,
                             input logic [3:0] tag, input logic [31:0] value, input bit care_tag);
        rd_t e;
        e.busy = busy; e.tag = tag; e.value = value;
        exp_q.push_back(e);
        care_q.push_back(care_tag);
        port_q.push_back(port);
        name_q.push_back(name);
    endtask

    task automatic drain();
        rd_t   e, o;
        bit    care, port;
        string name;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); care = care_q.pop_front();
            port = port_q.pop_front(); name = name_q.pop_front();
            o = port ? {rs2_busy, rs2_tag, rs2_value} : {rs1_busy, rs1_tag, rs1_value};
            if (!care) begin
                o.tag = 4'd0;
                e.tag = 4'd0;
            end
            check(name, o, e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; roll_back = 1'b0;
        id_rename_valid = 1'b0; id_rd = '0; id_rob_id = '0;
        cm_valid = 1'b0; cm_rd = '0; cm_rob_id = '0; cm_value = '0;
        id_rs1 = '0; id_rs2 = '0;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] rob, input logic [31:0] val);
        cm_valid = 1'b1; cm_rd = rd; cm_rob_id = rob; cm_value = val;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] rob);
        id_rename_valid = 1'b1; id_rd = rd; id_rob_id = rob;
    endtask

    function automatic rd_t model_read(input logic [4:0] idx);
        rd_t r;
        r.busy = m_busy[idx]; r.tag = m_tag[idx]; r.value = m_val[idx];
        if (idx == 5'd0) r = '0;
        else if (cm_valid && cm_rd == idx && m_busy[idx] && m_tag[idx] == cm_rob_id) begin
            r.busy = 1'b0;
            r.value = cm_value;
        end
        return r;
    endfunction

    task automatic model_step();
        logic clear_ok;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (rdy) begin
            clear_ok = (m_tag[cm_rd] == cm_rob_id) &&
                       !(id_rename_valid && !roll_back && id_rd == cm_rd);
            if (roll_back)
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            if (cm_valid && cm_rd != 5'd0) begin
                m_val[cm_rd] = cm_value;
                if (clear_ok) m_busy[cm_rd] = 1'b0;
            end
            if (id_rename_valid && id_rd != 5'd0 && !roll_back) begin
                m_busy[id_rd] = 1'b1;
                m_tag[id_rd] = id_rob_id;
            end
        end
    endtask

    initial begin
        rd_t e;
        idle(); rst = 1'b1;
        cycle(); cycle();
        idle();

        // reset state
        id_rs1 = 5; id_rs2 = 0;
        expect_rd("rst_x5", 0, 0, 0, 0, 1);
        expect_rd("rst_x0", 1, 0, 0, 0, 1);
        cycle();

        // commit without a prior rename: not bypassed, value lands next cycle
        do_commit(5, 3, 32'hDEADBEEF); id_rs1 = 5;
        expect_rd("cm_nobyp", 0, 0, 0, 0, 1);
        cycle(); idle();
        id_rs1 = 5;
        expect_rd("cm_x5", 0, 0, 0, 32'hDEADBEEF, 1);
        cycle();

        // rename is invisible in its own cycle, visible the next
        do_rename(7, 2); id_rs1 = 7;
        expect_rd("ren_same", 0, 0, 0, 0, 1);
        cycle(); idle();
        id_rs1 = 7;
        expect_rd("ren_x7", 0, 1, 2, 0, 1);
        cycle();
        do_commit(7, 2, 32'h11); id_rs1 = 7;
        expect_rd("byp_x7", 0, 0, 0, 32'h11, 0);
        cycle(); idle();
        id_rs1 = 7;
        expect_rd("cm_x7", 0, 0, 0, 32'h11, 0);
        cycle();

        // older producer commits while a younger one is pending
        do_rename(7, 2); cycle(); idle();
        do_rename(7, 9); cycle(); idle();
        do_commit(7, 2, 32'h22); id_rs1 = 7;
        expect_rd("young_byp", 0, 1, 9, 32'h11, 1);
        cycle(); idle();
        id_rs1 = 7;
        expect_rd("young_x7", 0, 1, 9, 32'h22, 1);
        cycle();

        // commit and rename of the same register in one cycle
        do_rename(4, 1); cycle(); idle();
        do_commit(4, 1, 32'h33); do_rename(4, 5); id_rs1 = 4;
        expect_rd("rc_byp", 0, 0, 0, 32'h33, 0);
        cycle(); idle();
        id_rs1 = 4;
        expect_rd("rc_x4", 0, 1, 5, 32'h33, 1);
        cycle();

        // roll-back with a same-cycle commit and an ignored rename
        do_rename(1, 4); cycle(); idle();
        do_rename(2, 5); cycle(); idle();
        do_rename(3, 6); cycle(); idle();
        roll_back = 1'b1; do_commit(2, 5, 32'h44); do_rename(8, 7);
        id_rs1 = 2; id_rs2 = 3;
        expect_rd("rb_byp", 0, 0, 0, 32'h44, 0);
        expect_rd("rb_x3_pre", 1, 1, 6, 0, 1);
        cycle(); idle();
        id_rs1 = 1; id_rs2 = 2;
        expect_rd("rb_x1", 0, 0, 0, 0, 0);
        expect_rd("rb_x2", 1, 0, 0, 32'h44, 0);
        cycle();
        id_rs1 = 3; id_rs2 = 8;
        expect_rd("rb_x3", 0, 0, 0, 0, 0);
        expect_rd("rb_x8", 1, 0, 0, 0, 0);
        cycle();

        // x0 writes are discarded
        do_rename(0, 3); do_commit(0, 0, 32'h55); id_rs1 = 0;
        expect_rd("x0_same", 0, 0, 0, 0, 1);
        cycle(); idle();
        id_rs1 = 0;
        expect_rd("x0_after", 0, 0, 0, 0, 1);
        cycle();

        // rdy low freezes state
        rdy = 1'b0; do_rename(3, 10); do_commit(7, 9, 32'h77);
        id_rs1 = 3; id_rs2 = 7;
        expect_rd("frz_x3_pre", 0, 0, 0, 0, 0);
        expect_rd("frz_x7_pre", 1, 0, 0, 32'h22, 0);
        cycle(); idle();
        id_rs1 = 3; id_rs2 = 7;
        expect_rd("frz_x3", 0, 0, 0, 0, 0);
        expect_rd("frz_x7", 1, 0, 0, 32'h22, 0);
        cycle();

        // reset overrides a same-cycle rename and commit
        rst = 1'b1; do_rename(5, 1); do_commit(6, 0, 32'h99);
        cycle(); idle();
        id_rs1 = 5; id_rs2 = 4;
        expect_rd("rst2_x5", 0, 0, 0, 0, 1);
        expect_rd("rst2_x4", 1, 0, 0, 0, 1);
        cycle();
        id_rs1 = 6; id_rs2 = 7;
        expect_rd("rst2_x6", 0, 0, 0, 0, 1);
        expect_rd("rst2_x7", 1, 0, 0, 0, 1);
        cycle();

        // random phase against the model, starting from reset state
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            idle();
            rdy       = ($urandom_range(0, 9) != 0);
            roll_back = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 1) == 1) begin
                cm_valid  = 1'b1;
                cm_rd     = 5'($urandom_range(0, 7));
                cm_rob_id = ($urandom_range(0, 2) != 0) ? m_tag[cm_rd] : 4'($urandom_range(0, 15));
                cm_value  = $urandom;
            end
            if ($urandom_range(0, 1) == 1)
                do_rename(5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = ($urandom_range(0, 3) == 0) ? cm_rd : 5'($urandom_range(0, 7));
            e = model_read(id_rs1);
            expect_rd("rnd_rs1", 0, e.busy, e.tag, e.value, e.busy || id_rs1 == 5'd0);
            e = model_read(id_rs2);
            expect_rd("rnd_rs2", 1, e.busy, e.tag, e.value, e.busy || id_rs2 == 5'd0);
            cycle();
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Architectural register file with per-register rename tags. It sits downstream of the reorder buffer's commit port and beside the decoder in the out-of-order core. On each commit it writes the value and clears the pending tag. For each decoded instruction it returns either a ready value or the ROB index still producing each source operand, and records the new producer of the destination register. A ROB roll-back clears every pending tag, while committed values are kept.

## Interface
- XLEN, 32: data width.
- ROB_IDX_W, 4: ROB index width (16-entry ROB).
- NREG, 32: architectural registers; x0 is hardwired to zero.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- id_rs1  in  5  source 1 index from the decoder.
- id_rs2  in  5  source 2 index from the decoder.
- id_rename_valid  in  1  the decoded instruction writes id_rd.
- id_rd  in  5  destination index.
- id_rob_id  in  ROB_IDX_W  ROB entry allocated to the decoded instruction.
- rs1_busy  out  1  source 1 is awaiting a ROB result.
- rs1_tag  out  ROB_IDX_W  producing ROB index; valid when rs1_busy=1.
- rs1_value  out  XLEN  register value; valid when rs1_busy=0.
- rs2_busy, rs2_tag, rs2_value  out  1/ROB_IDX_W/XLEN  same as the rs1 outputs, for source 2.
- cm_valid  in  1  ROB commits a register-writing instruction.
- cm_rd  in  5  commit destination.
- cm_rob_id  in  ROB_IDX_W  ROB index of the committing entry.
- cm_value  in  XLEN  commit result.
- roll_back  in  1  misprediction flush, one cycle wide.

## Operation
- State: value[NREG], busy[NREG], tag[NREG].
- Read ports are combinational over the current state plus the same-cycle commit bypass:
  - x0: always busy=0, value=0, tag=0.
  - Bypass case: cm_valid=1, cm_rd=rsN≠0, busy[rsN]=1 and tag[rsN]=cm_rob_id. Output busy=0 and value=cm_value.
  - Otherwise: output busy[rsN], tag[rsN], value[rsN].
- Reads never see a same-cycle rename. For addi x1,x1,1 the source returns x1's prior state.
- Commit, on a clock edge with rdy=1, cm_valid=1 and cm_rd≠0:
  - value[cm_rd] <= cm_value, unconditionally.
  - busy[cm_rd] <= 0 only if tag[cm_rd]=cm_rob_id and no same-cycle rename targets cm_rd.
  - A non-matching tag means a younger producer exists; busy and tag are left unchanged.
- Rename, on a clock edge with rdy=1, id_rename_valid=1, id_rd≠0 and roll_back=0:
  - busy[id_rd] <= 1 and tag[id_rd] <= id_rob_id.
  - When rename and commit hit the same rd in one cycle, rename wins for busy/tag and commit still writes value.
- Roll-back, on a clock edge with rdy=1 and roll_back=1:
  - busy[*] <= 0 for all registers.
  - Rename is ignored.
  - A same-cycle commit still writes its value. It is the committing head and older than the flush.
- Writes to x0 by commit or rename are discarded.
- rdy=0: no state change. Read ports still reflect the current state.

## Timing
- Read latency is 0 cycles (combinational).
- Commit and rename take effect at the next posedge; a read in the following cycle sees them.
- Reset: on posedge with rst=1, value[*]=0, busy[*]=0, tag[*]=0, regardless of rdy.
  - All outputs therefore read busy=0, tag=0, value=0.
  - Reset overrides commit, rename and roll-back in the same cycle.
- No handshake: the ROB guarantees at most one commit per cycle, and the decoder at most one rename per cycle.
- Tags wrap modulo 2^ROB_IDX_W. Uniqueness is guaranteed by the ROB (at most 16 in flight), so no wrap check is made here.

## Test plan
- Reset, then read x5 -> busy=0, value=0. Commit x5=0xDEADBEEF with tag 3, without a prior rename -> next cycle value=0xDEADBEEF, busy=0.
- Rename x7 to tag 2 -> next cycle rs1=x7 gives busy=1, tag=2. Commit x7 tag 2 value 0x11 -> same-cycle bypass gives busy=0, value=0x11; next cycle state busy=0.
- Rename x7 tag 2, then rename x7 tag 9. Commit tag 2 value 0x22 -> value[7]=0x22, busy=1, tag=9 retained.
- Same cycle: commit x4 tag 1 value 0x33, and rename x4 tag 5 -> next cycle busy=1, tag=5, value=0x33.
- Rename x1..x3 to tags 4..6, then pulse roll_back with commit x2 tag 5 value 0x44 and rename x8 tag 7 -> all busy=0, value[2]=0x44, x8 not busy.
- Rename and commit to x0 with value 0x55 -> x0 reads busy=0, value=0. Hold rdy=0 with a rename of x3 -> no state change.
